// File: rtl/axis_upsample2x_line.sv
// axis_upsample2x_line
// 2x nearest-neighbour upsampler for an AXI-Stream pixel stream.
// Each input row of LINE_WIDTH pixels becomes two output rows of
// 2*LINE_WIDTH pixels. The first output row is produced while the input
// row arrives (S_FILL). The second output row is replayed from a line
// buffer (S_REPEAT).
// Optional feature macro: UPS_TLAST_CHECK_EN. When it is defined,
// err_tlast becomes a sticky flag for s_axis_tlast seen on a column other
// than the last one. When it is undefined, err_tlast is tied to 0.

module axis_upsample2x_line #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err_tlast
);

    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

    typedef enum logic {
        S_FILL,
        S_REPEAT
    } state_t;

    state_t                r_state;
    logic [COL_W-1:0]      r_col;
    logic                  r_phase;
    logic                  r_rowDone;
    logic                  r_lastRec;
    logic                  r_rstDone;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_buf [LINE_WIDTH];

    logic                  w_sHs;
    logic                  w_mHs;
    logic [COL_W-1:0]      w_nextCol;
    logic                  w_sReady;

    // Input is taken only after reset has been released for one edge, only
    // while filling, never once the last column of the row is held (the row
    // must be replayed first), and only when the output register is empty
    // or its second copy is leaving this cycle.
    always_comb begin
        w_sReady = 1'b0;
        if (r_rstDone && (r_state == S_FILL) && !r_rowDone) begin
            w_sReady = !r_tvalid || (r_phase && m_axis_tready);
        end
    end

    assign s_axis_tready = w_sReady;
    assign w_sHs         = s_axis_tvalid && w_sReady;
    assign w_mHs         = r_tvalid && m_axis_tready;

    // Column wrap; also keeps the replay index inside the buffer when
    // LINE_WIDTH is not a power of two.
    always_comb begin
        w_nextCol = r_col + 1'b1;
        if (r_col == LAST_COL) begin
            w_nextCol = '0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

    // Line buffer: written once per accepted pixel; holds stale data across
    // reset, which is harmless because every row is refilled before replay.
    always_ff @(posedge clk) begin
        if (w_sHs) begin
            r_buf[r_col] <= s_axis_tdata;
        end
    end

    // Main FSM: fill-and-emit, then replay the stored row, each pixel twice.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_FILL;
            r_col     <= '0;
            r_phase   <= 1'b0;
            r_rowDone <= 1'b0;
            r_lastRec <= 1'b0;
            r_rstDone <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            r_rstDone <= 1'b1;
            case (r_state)
                S_FILL: begin
                    if (w_sHs) begin
                        r_tdata  <= s_axis_tdata;
                        r_tvalid <= 1'b1;
                        r_phase  <= 1'b0;
                        r_col    <= w_nextCol;
                        if (r_col == LAST_COL) begin
                            r_rowDone <= 1'b1;
                            r_lastRec <= s_axis_tlast;
                        end
                    end else if (w_mHs) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else if (r_rowDone) begin
                            r_state   <= S_REPEAT;
                            r_rowDone <= 1'b0;
                            r_phase   <= 1'b0;
                            r_tdata   <= r_buf[0];
                        end else begin
                            r_tvalid <= 1'b0;
                        end
                    end
                end
                S_REPEAT: begin
                    if (w_mHs) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            if (r_col == LAST_COL) begin
                                r_tlast <= r_lastRec;
                            end
                        end else if (r_col == LAST_COL) begin
                            r_state   <= S_FILL;
                            r_col     <= '0;
                            r_phase   <= 1'b0;
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_lastRec <= 1'b0;
                        end else begin
                            r_col   <= w_nextCol;
                            r_phase <= 1'b0;
                            r_tdata <= r_buf[w_nextCol];
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

`ifdef UPS_TLAST_CHECK_EN
    logic r_err;

    // Sticky framing error: tlast on any accepted pixel but the last column.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_sHs && s_axis_tlast && (r_col != LAST_COL)) begin
            r_err <= 1'b1;
        end
    end

    assign err_tlast = r_err;
`else
    assign err_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_upsample2x_line.sv
// tb_axis_upsample2x_line
// Scoreboard bench for axis_upsample2x_line (DATA_WIDTH=32, LINE_WIDTH=4).
// Stimulus pushes the expected upsampled beats of each row into a queue.
// A monitor on the falling edge pops one entry per output handshake.

module tb_axis_upsample2x_line;

    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          err_tlast;

    int checks   = 0;
    int failures = 0;
    int beatCount = 0;
    int readyMode = 0;
    logic [DW:0] expQ [$];

`ifdef UPS_TLAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    axis_upsample2x_line #(
        .DATA_WIDTH(DW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .err_tlast    (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: mode 0 always ready, mode 1 repeats 1,0,0,1.
    initial begin
        int cyc = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1) begin
                m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                cyc++;
            end else begin
                m_axis_tready = 1'b1;
                cyc = 0;
            end
        end
    end

    // Monitor: pop and compare on each output handshake, check stalls.
    initial begin
        logic          prevStall;
        logic [DW-1:0] prevData;
        logic [DW:0]   e;
        prevStall = 1'b0;
        prevData  = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 64'(m_axis_tvalid), 64'd1);
                    checkOutput("stall_data", 64'(m_axis_tdata), 64'(prevData));
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    checkOutput("sready_while_pending", 64'(s_axis_tready), 64'd0);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    beatCount++;
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=%0d required=none", m_axis_tdata);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", 64'(m_axis_tdata), 64'(e[DW-1:0]));
                        checkOutput("beat_last", 64'(m_axis_tlast), 64'(e[DW]));
                    end
                end
                prevStall = m_axis_tvalid && !m_axis_tready;
                prevData  = m_axis_tdata;
            end
        end
    end

    task automatic pushRow(input int a, input int b, input int c, input int d, input logic last);
        int px [4];
        px[0] = a; px[1] = b; px[2] = c; px[3] = d;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < LW; i++) begin
                expQ.push_back({1'b0, DW'(px[i])});
                expQ.push_back({(last && r == 1 && i == LW - 1), DW'(px[i])});
            end
        end
    endtask

    task automatic applyStimulus(input int data, input logic last);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_axis_tdata  = DW'(data);
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=0 required=1 data=%0d", data);
        end
    endtask

    task automatic sendRow(input int a, input int b, input int c, input int d, input logic last);
        applyStimulus(a, 1'b0);
        applyStimulus(b, 1'b0);
        applyStimulus(c, 1'b0);
        applyStimulus(d, last);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_sready", 64'(s_axis_tready), 64'd0);
        checkOutput("reset_mvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("reset_mlast", 64'(m_axis_tlast), 64'd0);
        checkOutput("reset_mdata", 64'(m_axis_tdata), 64'd0);
        checkOutput("reset_err", 64'(err_tlast), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("sready_before_first_edge", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        checkOutput("sready_after_release", 64'(s_axis_tready), 64'd1);
        @(posedge clk);
        #1;

        // Single row, downstream always ready.
        $display("[TB] basic row");
        beatCount = 0;
        pushRow(50, 60, 70, 80, 1'b1);
        sendRow(50, 60, 70, 80, 1'b1);
        waitDrain();
        checkOutput("basic_beats", 64'(beatCount), 64'd16);

        // Full frame of 12 rows, tlast only at the end.
        $display("[TB] full frame");
        beatCount = 0;
        for (int r = 0; r < 12; r++) begin
            pushRow(50 + r * 40, 60 + r * 40, 70 + r * 40, 80 + r * 40, r == 11);
        end
        for (int r = 0; r < 12; r++) begin
            sendRow(50 + r * 40, 60 + r * 40, 70 + r * 40, 80 + r * 40, r == 11);
        end
        waitDrain();
        checkOutput("frame_beats", 64'(beatCount), 64'd192);
        checkOutput("err_clean", 64'(err_tlast), 64'd0);

        // Backpressure pattern 1,0,0,1.
        $display("[TB] backpressure");
        readyMode = 1;
        beatCount = 0;
        pushRow(50, 60, 70, 80, 1'b1);
        sendRow(50, 60, 70, 80, 1'b1);
        waitDrain();
        checkOutput("bp_beats", 64'(beatCount), 64'd16);
        readyMode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while beat 11 (third replay beat) is on the output.
        $display("[TB] reset during replay");
        beatCount = 0;
        pushRow(10, 20, 30, 40, 1'b1);
        sendRow(10, 20, 30, 40, 1'b1);
        n = 0;
        while (beatCount < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("beats_before_reset", 64'(beatCount), 64'd10);
        #1;
        checkOutput("beat11_presented", 64'(m_axis_tdata), 64'd20);
        aresetn = 1'b0;
        #1;
        checkOutput("midreset_mvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("midreset_mdata", 64'(m_axis_tdata), 64'd0);
        checkOutput("midreset_mlast", 64'(m_axis_tlast), 64'd0);
        checkOutput("midreset_sready", 64'(s_axis_tready), 64'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        beatCount = 0;
        pushRow(90, 100, 110, 120, 1'b1);
        sendRow(90, 100, 110, 120, 1'b1);
        waitDrain();
        checkOutput("post_reset_beats", 64'(beatCount), 64'd16);

        // tlast on column 1: data flow unchanged, error flag only if enabled.
        $display("[TB] misplaced tlast");
        pushRow(50, 60, 70, 80, 1'b0);
        applyStimulus(50, 1'b0);
        applyStimulus(60, 1'b1);
        checkOutput("err_next_cycle", 64'(err_tlast), 64'(ERR_EXP));
        applyStimulus(70, 1'b0);
        applyStimulus(80, 1'b0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        waitDrain();
        checkOutput("err_sticky", 64'(err_tlast), 64'(ERR_EXP));
        pushRow(1, 2, 3, 4, 1'b1);
        sendRow(1, 2, 3, 4, 1'b1);
        waitDrain();
        checkOutput("err_sticky_later", 64'(err_tlast), 64'(ERR_EXP));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
